// File: rtl/mult_norm_pipe.sv
// Two-stage normaliser for floating-point multiplier products: stage 1 finds the leading one,
// stage 2 shifts the mantissa, adjusts the exponent and flags zero/underflow/overflow.
module mult_norm_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 48
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EXP_W-1:0] in_e,
  input  logic [MAN_W-1:0] in_m,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] out_e,
  output logic [MAN_W-1:0] out_m,
  output logic             out_sticky,
  output logic             out_zero,
  output logic             out_uf,
  output logic             out_of
);

  localparam int unsigned LzW = $clog2(MAN_W);
  localparam int unsigned XW  = EXP_W + 2;
  localparam logic signed [XW-1:0] ExpMax = XW'((2 ** EXP_W) - 1);

  logic             s1_valid;
  logic [EXP_W-1:0] s1_e;
  logic [MAN_W-1:0] s1_m;
  logic             s1_hi;
  logic             s1_zero;
  logic [LzW-1:0]   s1_lz;

  logic s1_adv;
  logic s2_adv;

  logic [LzW-1:0] lz;

  logic signed [XW-1:0] x;
  logic [MAN_W-1:0]     m_n;
  logic                 st_n;
  logic [EXP_W-1:0]     e_d;
  logic [MAN_W-1:0]     m_d;
  logic                 sticky_d;
  logic                 zero_d;
  logic                 uf_d;
  logic                 of_d;

  assign s2_adv   = ~out_valid | out_ready;
  assign s1_adv   = ~s1_valid | s2_adv;
  assign in_ready = s1_adv;

  // Highest set bit below the hidden-overflow bit wins; all-zero gives MAN_W-1.
  always_comb begin
    lz = LzW'(MAN_W - 1);
    for (int i = 0; i < int'(MAN_W) - 1; i++) begin
      if (in_m[i]) lz = LzW'(int'(MAN_W) - 2 - i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_e     <= '0;
      s1_m     <= '0;
      s1_hi    <= 1'b0;
      s1_zero  <= 1'b0;
      s1_lz    <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_e    <= in_e;
        s1_m    <= in_m;
        s1_hi   <= in_m[MAN_W-1];
        s1_zero <= (in_m == '0);
        s1_lz   <= lz;
      end
    end
  end

  always_comb begin
    x        = '0;
    m_n      = '0;
    st_n     = 1'b0;
    e_d      = '0;
    m_d      = '0;
    sticky_d = 1'b0;
    zero_d   = 1'b0;
    uf_d     = 1'b0;
    of_d     = 1'b0;
    if (s1_hi) begin
      m_n  = s1_m >> 1;
      st_n = s1_m[0];
      x    = $signed(XW'(s1_e) + XW'(1));
    end else begin
      m_n = s1_m << s1_lz;
      x   = $signed(XW'(s1_e) - XW'(s1_lz));
    end
    if (s1_zero) begin
      zero_d = 1'b1;
    end else if (x[XW-1] || (x == '0)) begin
      uf_d = 1'b1;
    end else if (x >= ExpMax) begin
      of_d = 1'b1;
      e_d  = '1;
    end else begin
      e_d      = x[EXP_W-1:0];
      m_d      = m_n;
      sticky_d = st_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_e      <= '0;
      out_m      <= '0;
      out_sticky <= 1'b0;
      out_zero   <= 1'b0;
      out_uf     <= 1'b0;
      out_of     <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_e      <= e_d;
        out_m      <= m_d;
        out_sticky <= sticky_d;
        out_zero   <= zero_d;
        out_uf     <= uf_d;
        out_of     <= of_d;
      end
    end
  end

endmodule

// File: doc/mult_norm_pipe.md
Name: mult_norm_pipe

Overview:
- Parametrised, pipelined normaliser for floating-point multiplier products.
- Takes a biased exponent and a raw 2.x product mantissa.
- Normalises the mantissa so its leading one sits at bit MAN_W-2, in both directions (right shift by 1 or left shift by any amount), with matching exponent adjustment.
- Sits between the mantissa multiplier and the rounding stage. Uses a valid/ready handshake on both sides and flags zero, underflow and overflow.

Parameters:
EXP_W, 8, biased exponent width
MAN_W, 48, product mantissa width; normalised leading one at bit MAN_W-2

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  input beat valid
in_ready  output  1  block can accept input this cycle
in_e  input  EXP_W  biased exponent of product
in_m  input  MAN_W  raw product mantissa
out_valid  output  1  output beat valid
out_ready  input  1  downstream accepts output this cycle
out_e  output  EXP_W  adjusted biased exponent
out_m  output  MAN_W  normalised mantissa
out_sticky  output  1  bit shifted out on right normalisation
out_zero  output  1  input mantissa was zero
out_uf  output  1  exponent underflow; result flushed to zero
out_of  output  1  exponent overflow; result forced to infinity

Behaviour:
- Reset (async, active-high): both stage valid bits clear; all output data registers and flags are 0.
- Stage 1 (S1) registers in_e and in_m plus:
  - hi = in_m[MAN_W-1];
  - lz = leading-zero count of in_m[MAN_W-2:0], range 0..MAN_W-1;
  - zero = (in_m == 0).
- Stage 2 (S2) registers the final results.
- Latency: exactly 2 cycles from accepted input to out_valid when there is no stall. Throughput: 1 beat per cycle.
- Handshake:
  - s2_adv = ~s2_valid | out_ready;
  - s1_adv = ~s1_valid | s2_adv;
  - in_ready = s1_adv.
  - A transfer occurs when valid & ready are both high on the same edge.
  - A held stage keeps its data and flags unchanged.
  - Beats are never dropped, duplicated or reordered.
- S2 arithmetic uses signed internal exponent width EXP_W+2; max = 2^EXP_W-1.
  - zero: out_m = 0, out_e = 0, out_zero = 1, other flags 0.
  - hi = 1: out_m = in_m >> 1, out_sticky = in_m[0], exponent x = in_e + 1.
  - else: out_m = in_m << lz (zero fill), out_sticky = 0, x = in_e - lz.
  - x <= 0: out_uf = 1, out_e = 0, out_m = 0, out_sticky = 0.
  - x >= max: out_of = 1, out_e = max, out_m = 0, out_sticky = 0.
  - otherwise: out_e = x[EXP_W-1:0].
- Flags are mutually exclusive. out_e, out_m and the flags are meaningful only while out_valid is high.
- in_e = max or in_e = 0 on input is not special-cased; the arithmetic rules above apply.
- Reset mid-stream: all in-flight beats are discarded; in_ready = 1 on the first cycle after reset deasserts.

Test Plan:
- Already normalised: in_m = 48'h4000_0000_0000, in_e = 127, out_ready = 1 -> 2 cycles later out_m = 48'h4000_0000_0000, out_e = 127, all flags 0.
- Right shift: in_m = 48'h8000_0000_0001, in_e = 127 -> out_m = 48'h4000_0000_0000, out_e = 128, out_sticky = 1.
- Deep left shift: in_m = 48'h0000_0000_0001, in_e = 100 (lz = 46) -> out_m = 48'h4000_0000_0000, out_e = 54.
- Range limits:
  - in_m = 48'h0200_0000_0000 (lz = 5), in_e = 3 -> out_uf = 1, out_e = 0, out_m = 0.
  - in_m = 48'h8000_0000_0000, in_e = 254 -> out_of = 1, out_e = 255, out_m = 0.
  - in_m = 0 -> out_zero = 1, out_e = 0.
- Backpressure: 4 back-to-back inputs (in_e = 10, 11, 12, 13) with out_ready = 0 for 5 cycles -> in_ready falls after 2 accepted. Outputs then emerge in order 10..13 once out_ready = 1, with no loss or duplication. Random valid/ready over 1000 beats must match a reference model.
- Reset mid-operation: assert reset with both stages full -> out_valid = 0 immediately (async). After release, in_ready = 1 and no stale beat appears.
